// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: loads a parallel word serially into a 16-bit bidirectional shift
// register, then reads the register back and flags any mismatch with the loaded word.
`default_nettype none

module shift_seq_ctrl #(
   parameter int N = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N:0]   in_data,
   input  logic         in_dir,
   output logic         sr_shift_en,
   output logic         sr_dir,
   output logic         sr_d_in,
   input  logic [N:0]   sr_q,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N:0]   out_data,
   output logic         out_err,
   output logic         busy
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_CAPT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [N:0]    tx;
   logic          dir_r;
   logic          rdy_r;
   logic [CW-1:0] bit_idx;
   logic          accept;

   // Ready is registered so it stays low for the first cycle after reset release.
   assign accept = in_valid && rdy_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rdy_r     <= 1'b0;
         cnt       <= '0;
         tx        <= '0;
         dir_r     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         rdy_r <= (state_nxt == S_IDLE);
         case (state)
            S_IDLE: begin
               if (accept) begin
                  tx    <= in_data;
                  dir_r <= in_dir;
                  cnt   <= '0;
               end
            end
            S_SHIFT: begin
               if (cnt != CNT_LAST) begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_CAPT: begin
               out_data  <= sr_q;
               out_err   <= (sr_q != tx);
               out_valid <= 1'b1;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Left shifts feed MSB first, right shifts LSB first, so the register ends holding tx.
   assign bit_idx = dir_r ? cnt : (CNT_LAST - cnt);

   always_comb begin
      state_nxt   = state;
      sr_shift_en = 1'b0;
      sr_d_in     = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sr_shift_en = 1'b1;
            sr_d_in     = tx[bit_idx];
            if (cnt == CNT_LAST) begin
               state_nxt = S_CAPT;
            end
         end
         S_CAPT: begin
            state_nxt = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign in_ready = rdy_r;
   assign sr_dir   = dir_r;
   assign busy     = (state != S_IDLE);

endmodule

`default_nettype wire
